tm_frame_receiver: RTL and testbench

Responder end of the two-wire (SCLK/DIN) LED-driver serial protocol that our pixel writer drives. It deserializes frames and decodes the three command types: data command 0x40/0x44, address command 0xC0|addr, display control 0x80/0x88|brightness. Decoded data goes into a 16×8 display RAM, and display state is exported. It sits on a second board, or in the bench, as an emulated display, and lets the transmitter be checked in-system.

---
 rtl/tm_proto_pkg.sv | 27 ++
 rtl/tm_line_sync.sv | 49 ++++
 rtl/tm_frame_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_tm_frame_receiver.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_proto_pkg.sv
// Shared definitions for the two-wire LED-driver serial protocol.
// Imported by the frame receiver, its line synchronizer, and the transmitter.
package tm_proto_pkg;

    // Command class lives in the top two bits of the first byte of a frame.
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit of a data command that selects fixed-address mode (1) or auto-increment (0).
    localparam int FIXED_BIT = 2;

    // Receiver frame state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        DATA   = 2'd2,
        IGNORE = 2'd3
    } tm_state_e;

    // Extract the command class from a command byte.
    function automatic logic [1:0] cmd_class(input logic [7:0] b);
        return b[7:6];
    endfunction

endpackage

// File: rtl/tm_line_sync.sv
// Synchronizes the asynchronous SCLK/DIN pair into the CLK domain and
// decodes bus events from the synchronized value and its one-cycle history.
module tm_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic din_i,
    output logic start_o,
    output logic stop_o,
    output logic bit_rise_o,
    output logic s_din_o
);

    // Idle bus is high, so every flop resets to 1; no event fires out of reset.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   p_clk_q;
    logic                   p_din_q;
    logic                   s_clk;
    logic                   s_din;

    assign s_clk = clk_sync_q[SYNC_STAGES-1];
    assign s_din = din_sync_q[SYNC_STAGES-1];

    // Synchronizer chains plus one history stage for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= '1;
            din_sync_q <= '1;
            p_clk_q    <= 1'b1;
            p_din_q    <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sclk_i};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din_i};
            p_clk_q    <= s_clk;
            p_din_q    <= s_din;
        end
    end

    // DIN moving while SCLK stays high is a start (falling) or stop (rising);
    // an SCLK rising edge is a data bit. The three cannot coincide.
    assign start_o    = p_clk_q & s_clk & p_din_q & ~s_din;
    assign stop_o     = p_clk_q & s_clk & ~p_din_q & s_din;
    assign bit_rise_o = ~p_clk_q & s_clk;
    assign s_din_o    = s_din;

endmodule

// File: rtl/tm_frame_receiver.sv
// Responder end of the SCLK/DIN LED-driver link: deserializes frames,
// decodes data/address/display-control commands, fills a 16x8 display RAM
// and exports the display state.
module tm_frame_receiver
    import tm_proto_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              DIN,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              disp_on,
    output logic [2:0]        brightness,
    output logic              frame_done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    // Write strobe semantics: wr_en is high for exactly one CLK cycle per RAM
    // byte written; wr_addr/wr_data are valid only while wr_en is high and the
    // RAM already holds the new byte in that cycle. There is no back-pressure.

    logic ev_start;
    logic ev_stop;
    logic ev_bit;
    logic s_din;

    tm_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sclk_i     (SCLK),
        .din_i      (DIN),
        .start_o    (ev_start),
        .stop_o     (ev_stop),
        .bit_rise_o (ev_bit),
        .s_din_o    (s_din)
    );

    tm_state_e         state_q, state_d;
    // Only the upper seven bits of the shifter are ever needed: the byte is
    // assembled with the incoming bit on the completing edge.
    logic [6:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fixed_q, fixed_d;
    logic              seen_q, seen_d;
    logic              disp_on_q, disp_on_d;
    logic [2:0]        bright_q, bright_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        rd_data_q;
    logic [7:0]        ram_q [DEPTH];
    logic [7:0]        byte_val;
    logic              byte_done;

    assign byte_val  = {s_din, shift_q};
    assign byte_done = ev_bit && (state_q != IDLE) && (bit_cnt_q == 3'd7);

    // Next-state and output decode for the frame FSM.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        fixed_d      = fixed_q;
        seen_d       = seen_q;
        disp_on_d    = disp_on_q;
        bright_d     = bright_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_d        = 1'b0;
        frame_done_d = 1'b0;

        if (ev_start || ev_stop) begin
            bit_cnt_d = 3'd0;
            // A partial byte is dropped and the whole frame counts as aborted,
            // so a later stop cannot report it as done.
            if (bit_cnt_q != 3'd0) begin
                err_d  = 1'b1;
                seen_d = 1'b0;
            end
            if (ev_start) begin
                state_d = CMD;
            end else begin
                state_d      = IDLE;
                frame_done_d = seen_q && (bit_cnt_q == 3'd0);
                seen_d       = 1'b0;
            end
        end else if (ev_bit && (state_q != IDLE)) begin
            shift_d   = byte_val[7:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
                seen_d = 1'b1;
                unique case (state_q)
                    CMD: begin
                        unique case (cmd_class(byte_val))
                            CMD_DATA: begin
                                fixed_d = byte_val[FIXED_BIT];
                                state_d = IGNORE;
                            end
                            CMD_ADDR: begin
                                addr_d  = ADDR_W'(byte_val[3:0]);
                                state_d = DATA;
                            end
                            CMD_CTRL: begin
                                disp_on_d = byte_val[3];
                                bright_d  = byte_val[2:0];
                                state_d   = IGNORE;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = IGNORE;
                            end
                        endcase
                    end
                    DATA: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = byte_val;
                        if (!fixed_q) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                    IGNORE: begin
                        err_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            fixed_q      <= 1'b0;
            seen_q       <= 1'b0;
            disp_on_q    <= 1'b0;
            bright_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            fixed_q      <= fixed_d;
            seen_q       <= seen_d;
            disp_on_q    <= disp_on_d;
            bright_q     <= bright_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Display RAM: written alongside the wr_en strobe, cleared by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else if (wr_en_d) begin
            ram_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= ram_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign disp_on    = disp_on_q;
    assign brightness = bright_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tm_frame_receiver.sv
// Bench for tm_frame_receiver: emulates the pixel-writer transmitter on
// SCLK/DIN, predicts output events with a frame-level model, and compares
// them in a free-running monitor.
module tb_tm_frame_receiver;
  import tm_proto_pkg::*;

  localparam int W = 14;  // {kind[1:0], field[3:0], data[7:0]}
  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_CTRL = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;
  localparam logic [1:0] K_FD   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sclk_r = 1'b1;
  logic       din_r = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       disp_on;
  logic [2:0] brightness;
  logic       frame_done;
  logic       err;
  logic [1:0] dbg_state;

  tm_frame_receiver #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SCLK       (sclk_r),
    .DIN        (din_r),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_on    (disp_on),
    .brightness (brightness),
    .frame_done (frame_done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_ram[16];
  logic         m_fixed;
  logic         m_disp;
  logic [2:0]   m_bright;
  logic [7:0]   fr[$];
  logic [3:0]   prev_ctrl = 4'd0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic check_ev(input logic [W-1:0] got, input string name);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event %h, required none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got event %h required %h", name, got, e);
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d events still pending, required 0 (next %h)", name, exp_q.size(), exp_q[0]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_ctrl = 4'd0;
    end else begin
      if (wr_en) check_ev({K_WR, wr_addr, wr_data}, "write");
      if ({disp_on, brightness} != prev_ctrl) check_ev({K_CTRL, disp_on, brightness, 8'h00}, "display_ctrl");
      if (err) check_ev({K_ERR, 12'h000}, "err");
      if (frame_done) check_ev({K_FD, 12'h000}, "frame_done");
      prev_ctrl = {disp_on, brightness};
    end
  end

  // ---------------- reference model (frame level) ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed  = 1'b0;
    m_disp   = 1'b0;
    m_bright = 3'd0;
    exp_q.delete();
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [3:0] f, input logic [7:0] d);
    exp_q.push_back({k, f, d});
  endtask

  // A frame is a command byte followed by payload bytes. Address commands
  // turn the payload into writes; every other command makes payload an error.
  task automatic model_frame(input logic [7:0] bytes[$]);
    logic [7:0] c;
    int         a;
    logic       takes_data;
    if (bytes.size() == 0) return;
    c = bytes[0];
    a = 0;
    takes_data = 1'b0;
    if (c[7:6] == 2'b01) begin
      m_fixed = c[2];
    end else if (c[7:6] == 2'b11) begin
      a = int'(c[3:0]);
      takes_data = 1'b1;
    end else if (c[7:6] == 2'b10) begin
      if ({c[3], c[2:0]} != {m_disp, m_bright}) push_ev(K_CTRL, {c[3], c[2:0]}, 8'h00);
      m_disp   = c[3];
      m_bright = c[2:0];
    end else begin
      push_ev(K_ERR, 4'h0, 8'h00);
    end
    for (int i = 1; i < bytes.size(); i++) begin
      if (takes_data) begin
        push_ev(K_WR, 4'(a), bytes[i]);
        m_ram[a] = bytes[i];
        if (!m_fixed) a = (a + 1) % 16;
      end else begin
        push_ev(K_ERR, 4'h0, 8'h00);
      end
    end
    push_ev(K_FD, 4'h0, 8'h00);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sclk_r = 1'b0;
    wait_clk(2);
    din_r = b;
    wait_clk(3);
    sclk_r = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  // Bus rests with SCLK high; a start is DIN falling from high.
  task automatic bus_start();
    din_r = 1'b0;
    wait_clk(4);
  endtask

  // A stop needs DIN low first; if the last bit left it high, lowering it
  // with SCLK high is a clean repeated start that precedes the stop.
  task automatic bus_stop();
    if (din_r) begin
      din_r = 1'b0;
      wait_clk(4);
    end
    din_r = 1'b1;
    wait_clk(4);
  endtask

  task automatic run_frame(input logic [7:0] bytes[$], input string name);
    model_frame(bytes);
    bus_start();
    foreach (bytes[i]) send_byte(bytes[i]);
    bus_stop();
    wait_clk(8);
    check_drained(name);
  endtask

  task automatic read_check(input int a, input logic [7:0] want, input string name);
    rd_addr = 4'(a);
    wait_clk(2);
    check_val($sformatf("%s[%0d]", name, a), 32'(rd_data), 32'(want));
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 16; i++) read_check(i, m_ram[i], name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sclk_r = 1'b1;
    din_r = 1'b1;
    model_reset();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic check_all_zero(input string name);
    logic [1:0] idle_st;
    idle_st = IDLE;
    check_val({name, "_outputs"},
              32'({rd_data, wr_en, wr_addr, wr_data, disp_on, brightness, frame_done, err}), 32'd0);
    check_val({name, "_state"}, 32'(dbg_state), 32'(idle_st));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800us;
    $display("FAIL watchdog: got no completion, required finish within 800us");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] idle_st;
    logic [7:0] b;
    int len;
    idle_st = IDLE;

    // reset
    do_reset();
    check_all_zero("reset");
    read_all("reset_ram");

    // full-screen write
    fr = '{8'h40};
    run_frame(fr, "data_cmd");
    fr = '{8'hC0, 8'h06, 8'h5B, 8'h4F, 8'hE6};
    for (int i = 0; i < 10; i++) fr.push_back(8'($urandom));
    fr.push_back(8'hC7);
    fr.push_back(8'hFF);
    run_frame(fr, "full_screen");
    read_all("full_screen_ram");

    // display control
    fr = '{8'h89};
    run_frame(fr, "ctrl_on");
    check_val("disp_on_after_89", 32'(disp_on), 32'd1);
    check_val("brightness_after_89", 32'(brightness), 32'd1);

    // reset pulse mid-idle clears everything
    do_reset();
    check_all_zero("idle_reset");
    read_all("idle_reset_ram");

    fr = '{8'h89};
    run_frame(fr, "ctrl_on2");
    fr = '{8'h80};
    run_frame(fr, "ctrl_off");
    check_val("disp_on_after_80", 32'(disp_on), 32'd0);

    // fixed address mode persists into the next frame
    fr = '{8'h44};
    run_frame(fr, "fixed_cmd");
    fr = '{8'hC5, 8'hAA, 8'h55};
    run_frame(fr, "fixed_write");
    read_check(5, 8'h55, "fixed_ram");
    read_check(6, m_ram[6], "fixed_ram_neighbor");

    // auto-increment wraps 15 -> 0
    fr = '{8'h40};
    run_frame(fr, "auto_cmd");
    fr = '{8'hCF, 8'h11, 8'h22};
    run_frame(fr, "wrap_write");
    read_check(15, 8'h11, "wrap_ram");
    read_check(0, 8'h22, "wrap_ram");

    // partial byte at stop: one err, no write, no frame_done
    push_ev(K_ERR, 4'h0, 8'h00);
    bus_start();
    send_byte(8'hC3);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus_stop();
    wait_clk(8);
    check_drained("partial_byte");

    fr = '{8'h00};
    run_frame(fr, "bad_cmd");
    fr = '{8'h89, 8'h12};
    run_frame(fr, "ctrl_extra_byte");

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      fr.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        fr.push_back(b);
      end
      run_frame(fr, "random_frame");
    end
    read_all("random_ram");

    // reset in the middle of a data byte to address 2
    bus_start();
    send_byte(8'hC2);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    wait_clk(1);
    check_val("midframe_state_in_reset", 32'(dbg_state), 32'(idle_st));
    do_reset();
    check_all_zero("midframe_reset");
    read_all("midframe_ram");
    fr = '{8'h40};
    run_frame(fr, "after_reset_cmd");
    fr = '{8'hC2, 8'h3C, 8'h5A};
    run_frame(fr, "after_reset_write");
    read_check(2, 8'h3C, "after_reset_ram");
    read_check(3, 8'h5A, "after_reset_ram");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
